acumulador_ctrl: RTL and testbench

ACUMULADOR_CTRL -- requirements
Module: acumulador_ctrl

---
 rtl/acumulador_ctrl_if.sv | 29 ++
 rtl/acumulador_ctrl.sv | 131 +++++++++++++
 tb/tb_acumulador_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/acumulador_ctrl_if.sv
// Request/datapath bundle between a run requester (master) and acumulador_ctrl (slave).
interface acumulador_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  carry;
  logic [ADDR_WIDTH-1:0] address;
  logic                  mem_read;
  logic                  load;
  logic                  clear;
  logic                  transfer;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output start, abort, base_addr, len, carry,
    input  address, mem_read, load, clear, transfer, busy, done, overflow
  );

  modport slave (
    input  start, abort, base_addr, len, carry,
    output address, mem_read, load, clear, transfer, busy, done, overflow
  );
endinterface

// File: rtl/acumulador_ctrl.sv
// Sequencer for a memory-fed accumulator: clear, then fetch/load/add per word, then pulse done.
// Define ACUMULADOR_CTRL_OVF_EN to build the sticky overflow flag fed by the adder carry.
module acumulador_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  acumulador_ctrl_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StClear, StFetch, StLoad, StAdd, StDone} state_e;

  state_e                st_q, st_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  idx_inc;
  logic [ADDR_WIDTH-1:0] addr_sum;

  logic [ADDR_WIDTH-1:0] address;
  logic                  mem_read, load, clear, transfer, busy, done;

  assign idx_inc  = idx_q + LEN_WIDTH'(1);
  assign addr_sum = base_q + ADDR_WIDTH'(idx_q);

  always_comb begin
    st_d   = st_q;
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    unique case (st_q)
      StIdle: begin
        if (bus_io.start) begin
          base_d = bus_io.base_addr;
          len_d  = bus_io.len;
          idx_d  = '0;
          st_d   = StClear;
        end
      end
      StClear: st_d = (len_q == '0) ? StDone : StFetch;
      StFetch: st_d = StLoad;
      StLoad:  st_d = StAdd;
      StAdd: begin
        idx_d = idx_inc;
        st_d  = (idx_inc == len_q) ? StDone : StFetch;
      end
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
    // Abort overrides every transition out of the active run states.
    if (bus_io.abort && (st_q inside {StClear, StFetch, StLoad, StAdd})) begin
      st_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q   <= StIdle;
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      st_q   <= st_d;
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  // Outputs decode from state only, so reset zeroes them without waiting for a clock.
  always_comb begin
    address  = '0;
    mem_read = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;
    transfer = 1'b0;
    done     = 1'b0;
    busy     = (st_q != StIdle);
    unique case (st_q)
      StClear: clear = 1'b1;
      StFetch: begin
        mem_read = 1'b1;
        address  = addr_sum;
      end
      StLoad: begin
        load    = 1'b1;
        address = addr_sum;
      end
      StAdd:   transfer = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.address  = address;
  assign bus_io.mem_read = mem_read;
  assign bus_io.load     = load;
  assign bus_io.clear    = clear;
  assign bus_io.transfer = transfer;
  assign bus_io.busy     = busy;
  assign bus_io.done     = done;

`ifdef ACUMULADOR_CTRL_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (st_q == StClear) begin
      ovf_d = 1'b0;
    end else if ((st_q == StAdd) && bus_io.carry) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus_io.overflow = ovf_q;
`else
  logic unused_carry;
  assign unused_carry    = bus_io.carry;
  assign bus_io.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_acumulador_ctrl.sv
// Directed bench for acumulador_ctrl with a small memory and 16-bit accumulator datapath model.
module tb_acumulador_ctrl;

`ifdef ACUMULADOR_CTRL_OVF_EN
  localparam logic OvfExp = 1'b1;
`else
  localparam logic OvfExp = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  acumulador_ctrl_if #(.ADDR_WIDTH(8), .LEN_WIDTH(8)) bus ();

  acumulador_ctrl #(.ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: memory data valid the cycle after MemRead, Load latches it, Transfer adds.
  logic [15:0] mem [256];
  logic [15:0] mem_dat;
  logic [15:0] b_q;
  logic [15:0] acc;
  logic [16:0] sum;

  assign sum       = {1'b0, acc} + {1'b0, b_q};
  assign bus.carry = sum[16];

  always @(posedge clk) begin
    if (bus.mem_read) mem_dat <= mem[bus.address];
    if (bus.load)     b_q     <= mem_dat;
    if (bus.clear)    acc     <= 16'h0;
    else if (bus.transfer) acc <= sum[15:0];
  end

  logic [7:0] addr_q[$];
  int         strobe_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'b0, bus.address, bus.mem_read, bus.load, bus.clear, bus.transfer,
            bus.busy, bus.done, bus.overflow};
  endfunction

  // flags order: mem_read, load, clear, transfer, busy, done, overflow
  function automatic logic [31:0] exp_o(input logic [7:0] a, input logic [6:0] f);
    return {17'b0, a, f};
  endfunction

  // Launches a run and steps until Done (bounded); Done lands on cycle done_cyc after the Start edge.
  task automatic run(input logic [7:0] base, input logic [7:0] n, input int restart_at,
                     output int done_cyc);
    addr_q.delete();
    done_cyc   = 0;
    strobe_err = 0;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len       = n;
    step();
    bus.base_addr = ~base;
    bus.len       = n + 8'd3;
    for (int c = 1; c <= 800; c++) begin
      bus.start = (c == restart_at);
      if ($countones({bus.mem_read, bus.load, bus.clear, bus.transfer, bus.done}) != 1 ||
          !bus.busy) strobe_err++;
      if (bus.mem_read) addr_q.push_back(bus.address);
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      step();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int dc;
    int cnt;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[8'h10] = 16'd5;
    mem[8'h11] = 16'd7;
    mem[8'h12] = 16'd9;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = 8'h0;
    bus.len       = 8'h0;
    #2;
    chk("reset_outs", outs(), 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_outs", outs(), 32'h0);

    // Basic run with a Start repeated mid-run and input changes after latch.
    run(8'h10, 8'd3, 5, dc);
    chk("len3_done_cycle", dc, 11);
    chk("len3_addr_cnt", addr_q.size(), 3);
    chk("len3_addr0", addr_q[0], 8'h10);
    chk("len3_addr1", addr_q[1], 8'h11);
    chk("len3_addr2", addr_q[2], 8'h12);
    chk("len3_acc", acc, 16'd21);
    chk("len3_onehot", strobe_err, 0);
    step();
    chk("len3_back_idle", outs(), 32'h0);
    step();
    chk("len3_no_restart", outs(), 32'h0);

    // Len=0 with Start and Abort together in IDLE: Start wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.len   = 8'd0;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("len0_clear", outs(), exp_o(8'h0, 7'b0010100));
    step();
    chk("len0_done", outs(), exp_o(8'h0, 7'b0000110));
    step();
    chk("len0_idle", outs(), 32'h0);

    // Address wrap-around.
    run(8'hFE, 8'd4, 0, dc);
    chk("wrap_done_cycle", dc, 14);
    chk("wrap_addr_cnt", addr_q.size(), 4);
    chk("wrap_addr0", addr_q[0], 8'hFE);
    chk("wrap_addr1", addr_q[1], 8'hFF);
    chk("wrap_addr2", addr_q[2], 8'h00);
    chk("wrap_addr3", addr_q[3], 8'h01);
    step();

    // Abort during second LOAD of a Len=5 run.
    bus.start     = 1'b1;
    bus.base_addr = 8'h20;
    bus.len       = 8'd5;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("abort_at_load", outs(), exp_o(8'h21, 7'b0100100));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_idle", outs(), 32'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done || bus.busy) cnt++;
      step();
    end
    chk("abort_no_done", cnt, 0);
    run(8'h20, 8'd5, 0, dc);
    chk("after_abort_done_cycle", dc, 17);
    chk("after_abort_addr_cnt", addr_q.size(), 5);
    step();

    // Maximum length run.
    run(8'h00, 8'd255, 0, dc);
    chk("len255_done_cycle", dc, 767);
    chk("len255_addr_cnt", addr_q.size(), 255);
    chk("len255_last_addr", addr_q[254], 8'hFE);
    chk("len255_onehot", strobe_err, 0);
    step();
    chk("len255_idle", outs(), 32'h0);

    // Overflow from 0xFFFF + 0x0001.
    mem[8'h40] = 16'hFFFF;
    mem[8'h41] = 16'h0001;
    run(8'h40, 8'd2, 0, dc);
    chk("ovf_done_cycle", dc, 8);
    chk("ovf_acc", acc, 16'h0000);
    chk("ovf_flag_done", bus.overflow, OvfExp);
    step();
    chk("ovf_flag_idle", outs(), exp_o(8'h0, {6'b0, OvfExp}));

    // Next run clears the flag in CLEAR; then reset lands mid-FETCH.
    bus.start     = 1'b1;
    bus.base_addr = 8'h10;
    bus.len       = 8'd3;
    step();
    bus.start = 1'b0;
    step();
    chk("fetch_ovf_cleared", outs(), exp_o(8'h10, 7'b1000100));
    rst = 1'b1;
    #1;
    chk("reset_mid_fetch", outs(), 32'h0);
    step();
    step();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done || bus.busy) cnt++;
      step();
    end
    chk("reset_no_done", cnt, 0);
    run(8'h10, 8'd1, 0, dc);
    chk("fresh_done_cycle", dc, 5);
    chk("fresh_addr0", addr_q[0], 8'h10);
    chk("fresh_acc", acc, 16'd5);
    step();
    chk("fresh_idle", outs(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
